sprite_rom_arbiter: RTL and testbench
=====================================

# sprite_rom_arbiter

Shares one synchronous sprite/palette-index ROM read port among up to NUM_REQ pixel-pipeline requesters (player, enemy and tile renderers) on the VGA pixel clock. Performs round-robin arbitration, drives the ROM address, and returns each read's data to the originating requester with a per-requester valid strobe. Sits between the per-object draw logic and the `*_rom` instance it feeds into the palette lookup.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 8, ROM address width
- DATA_W, 2, ROM word (palette index) width
- ROM_LAT, 1, cycles from rom_address registered to rom_q stable (1..3)
- LOCK_MAX, 16, max consecutive grants under lock (only with SPRITE_ARB_LOCK_EN)

- vga_clk  in  1  pixel clock; all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  request per requester; level, held until gnt
- addr  in  NUM_REQ*ADDR_W  requester i address at bits [i*ADDR_W +: ADDR_W]
- lock  in  NUM_REQ  burst-hold request (ignored without SPRITE_ARB_LOCK_EN)
- gnt  out  NUM_REQ  one-hot, registered, one-cycle pulse per accepted request
- rom_address  out  ADDR_W  registered address to ROM
- rom_q  in  DATA_W  ROM read data
- rdata  out  DATA_W  registered read data, broadcast
- rvalid  out  NUM_REQ  one-hot, marks owner of rdata this cycle
- busy  out  1  high while any read is in flight

## Operation
- Each cycle, arbiter selects at most one requester with req=1, searching from round-robin pointer ptr upward with wrap (ptr, ptr+1, ..., NUM_REQ-1, 0, ...).
- On the edge: gnt[sel]<=1, rom_address<=addr[sel], ptr<=sel+1 mod NUM_REQ; tag sel enters an in-flight shift register of depth ROM_LAT+1.
- No req: gnt<=0, rom_address holds, ptr holds, empty tag enters pipeline.
- Requester seeing gnt may change addr or drop req in the same cycle; req still high after gnt = new request, competes normally (eligible next cycle).
- Tag exits pipeline: rdata<=rom_q, rvalid[tag]<=1; empty tag: rvalid<=0, rdata holds.
- busy = OR of valid bits in tag pipeline.
- Throughput: one grant per cycle; with all requesters active each is granted every NUM_REQ cycles.
- Reset (any time, async): gnt=0, rvalid=0, rdata=0, rom_address=0, ptr=0, busy=0, tag pipeline cleared; in-flight reads are discarded and never produce rvalid.

## Timing
- Request sampled at edge t -> gnt high in cycle t..t+1 and rom_address valid from edge t.
- rvalid[i] and rdata asserted at edge t+ROM_LAT+1, exactly ROM_LAT+1 cycles after the gnt[i] pulse edge, for one cycle.
- Order of rvalid matches order of grants; no reordering, no drops.
- Simultaneous requests: only pointer order decides; lowest index wins only when ptr=0.
- ptr wrap: grant to NUM_REQ-1 sets ptr=0.

## Configuration
- SPRITE_ARB_LOCK_EN defined: if the requester granted last cycle has req=1 and lock=1, it is granted again regardless of ptr, up to LOCK_MAX consecutive grants; after LOCK_MAX the lock is ignored for one arbitration and normal round-robin resumes from sel+1. Lock counter resets to 0 on any non-locked grant, idle cycle or reset.
- Not defined: lock input ignored, pure round-robin; LOCK_MAX unused.

## Test plan
- Reset: hold reset_n=0 with req=4'b1111 -> gnt=0, rvalid=0, rdata=0, rom_address=0, busy=0; release -> first gnt=4'b0001.
- Single requester: req=4'b0100, addr2=8'h5A, ROM_LAT=1 -> gnt=4'b0100 one cycle, rom_address=8'h5A, rvalid=4'b0100 with rdata=ROM[8'h5A] two cycles after gnt.
- All four held high 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,...; rvalid same sequence delayed ROM_LAT+1, each rdata matching its address.
- Wrap/priority: after grant to 3, req=4'b1001 -> grant 0; next cycle grant 3.
- Reset asserted with 2 reads in flight -> no rvalid ever appears for them; busy=0 immediately.
- With SPRITE_ARB_LOCK_EN, LOCK_MAX=16: req=4'b0011, lock[0]=1 -> 16 consecutive gnt=4'b0001, then gnt=4'b0010, then 0 again; without macro -> strict alternation.

Source files
------------

// File: rtl/sprite_rom_arbiter_if.sv
// Requester-side bundle for sprite_rom_arbiter: level requests, packed addresses,
// lock hints in; one-hot grants, broadcast read data and one-hot read-valid out.
interface sprite_rom_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 2
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ-1:0]        lock;
    logic [NUM_REQ-1:0]        gnt;
    logic [DATA_W-1:0]         rdata;
    logic [NUM_REQ-1:0]        rvalid;

    modport master (
        output req, addr, lock,
        input  gnt, rdata, rvalid
    );

    modport slave (
        input  req, addr, lock,
        output gnt, rdata, rvalid
    );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM read port among NUM_REQ
// pixel requesters; optional burst lock is enabled by defining SPRITE_ARB_LOCK_EN.
module sprite_rom_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 2,
    parameter int ROM_LAT  = 1,
    parameter int LOCK_MAX = 16
) (
    input  logic                vga_clk,
    input  logic                reset_n,
    sprite_rom_arbiter_if.slave req_if,
    output logic [ADDR_W-1:0]   rom_address,
    input  logic [DATA_W-1:0]   rom_q,
    output logic                busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int DEPTH = ROM_LAT + 1;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;

    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [ADDR_W-1:0]    rom_address_q, rom_address_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic [NUM_REQ-1:0]   rvalid_q, rvalid_d;
    tag_t [DEPTH-1:0]     tag_q, tag_d;

    logic [ADDR_W-1:0]    addr_arr [NUM_REQ];
    logic                 rr_valid, sel_valid;
    logic [IDX_W-1:0]     rr_sel, sel;

`ifdef SPRITE_ARB_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    logic [CNT_W-1:0]     lock_cnt_q, lock_cnt_d;
    logic [IDX_W-1:0]     last_idx_q, last_idx_d;
    logic                 lock_grant;
`else
    // Lock hint and its limit have no function in the pure round-robin build.
    logic                 lock_unused;
    assign lock_unused = ^{req_if.lock, LOCK_MAX};
`endif

    always_comb begin : unpack_addr
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i] = req_if.addr[i*ADDR_W +: ADDR_W];
        end
    end

    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin : rr_search
        logic [IDX_W-1:0] cand;
        rr_valid = 1'b0;
        rr_sel   = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((32'(ptr_q) + k) % NUM_REQ);
            if (!rr_valid && req_if.req[cand]) begin
                rr_valid = 1'b1;
                rr_sel   = cand;
            end
        end
    end

    always_comb begin : arbitrate
        sel_valid = rr_valid;
        sel       = rr_sel;
`ifdef SPRITE_ARB_LOCK_EN
        // Re-grant the previous owner while it holds lock; count is of extra grants beyond the first.
        lock_grant = (|gnt_q) && req_if.req[last_idx_q] && req_if.lock[last_idx_q]
                     && (lock_cnt_q < CNT_W'(LOCK_MAX - 1));
        if (lock_grant) begin
            sel_valid = 1'b1;
            sel       = last_idx_q;
        end
        lock_cnt_d = lock_grant ? lock_cnt_q + 1'b1 : '0;
        last_idx_d = sel_valid ? sel : last_idx_q;
`endif

        gnt_d         = '0;
        ptr_d         = ptr_q;
        rom_address_d = rom_address_q;
        if (sel_valid) begin
            gnt_d[sel]    = 1'b1;
            ptr_d         = (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
            rom_address_d = addr_arr[sel];
        end
    end

    always_comb begin : tag_pipe
        tag_d[0].valid = sel_valid;
        tag_d[0].idx   = sel;
        for (int i = 1; i < DEPTH; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        rvalid_d = '0;
        rdata_d  = rdata_q;
        if (tag_q[DEPTH-1].valid) begin
            rvalid_d[tag_q[DEPTH-1].idx] = 1'b1;
            rdata_d                      = rom_q;
        end
    end

    always_comb begin : busy_or
        busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            busy = busy | tag_q[i].valid;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the tag pipeline is
    // reset too, because a stale valid bit would fire rvalid for a discarded read.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q         <= '0;
            gnt_q         <= '0;
            rom_address_q <= '0;
            rdata_q       <= '0;
            rvalid_q      <= '0;
            tag_q         <= '0;
`ifdef SPRITE_ARB_LOCK_EN
            lock_cnt_q    <= '0;
            last_idx_q    <= '0;
`endif
        end else begin
            ptr_q         <= ptr_d;
            gnt_q         <= gnt_d;
            rom_address_q <= rom_address_d;
            rdata_q       <= rdata_d;
            rvalid_q      <= rvalid_d;
            tag_q         <= tag_d;
`ifdef SPRITE_ARB_LOCK_EN
            lock_cnt_q    <= lock_cnt_d;
            last_idx_q    <= last_idx_d;
`endif
        end
    end

    assign req_if.gnt    = gnt_q;
    assign req_if.rdata  = rdata_q;
    assign req_if.rvalid = rvalid_q;
    assign rom_address   = rom_address_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a ROM model and a read-return scoreboard.
module tb_sprite_rom_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 2;
    localparam int ROM_LAT  = 1;
    localparam int LOCK_MAX = 16;

    typedef struct {
        int                idx;
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;

    logic              vga_clk = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] rom_address;
    logic [DATA_W-1:0] rom_q;
    logic              busy;

    logic [ADDR_W-1:0] drv_addr [NUM_REQ];
    logic [DATA_W-1:0] rom_pipe [ROM_LAT];
    exp_t              sb [$];
    int                cycle    = 0;
    int                n_checks = 0;
    int                n_errors = 0;

    always #5 vga_clk = ~vga_clk;

    sprite_rom_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sprite_rom_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .ROM_LAT (ROM_LAT),
        .LOCK_MAX(LOCK_MAX)
    ) dut (
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .req_if     (bus),
        .rom_address(rom_address),
        .rom_q      (rom_q),
        .busy       (busy)
    );

    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] t;
        t = a ^ (a >> 3) ^ (a >> 5);
        return t[DATA_W-1:0];
    endfunction

    // Synchronous ROM: address captured on the edge, data stable ROM_LAT edges later.
    always @(posedge vga_clk) begin
        rom_pipe[0] <= rom_word(rom_address);
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_q = rom_pipe[ROM_LAT-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    task automatic apply_addr();
        for (int i = 0; i < NUM_REQ; i++) bus.addr[i*ADDR_W +: ADDR_W] = drv_addr[i];
    endtask

    // One clock: sample at the falling edge, retire due reads, record new grants.
    task automatic tick();
        logic [NUM_REQ-1:0] exp_rv;
        @(posedge vga_clk);
        @(negedge vga_clk);
        cycle++;
        exp_rv = '0;
        if (sb.size() > 0 && sb[0].due == cycle) begin
            exp_rv[sb[0].idx] = 1'b1;
            check("rdata", 32'(bus.rdata), 32'(sb[0].data));
            void'(sb.pop_front());
        end
        check("rvalid", 32'(bus.rvalid), 32'(exp_rv));
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.gnt[i]) begin
                check("rom_address", 32'(rom_address), 32'(drv_addr[i]));
                sb.push_back('{idx: i, data: rom_word(drv_addr[i]), due: cycle + ROM_LAT + 1});
                drv_addr[i] = drv_addr[i] + 8'h37;
            end
        end
        apply_addr();
    endtask

    task automatic step(input logic [NUM_REQ-1:0] exp_gnt, input string tag);
        tick();
        check(tag, 32'(bus.gnt), 32'(exp_gnt));
    endtask

    initial begin
        logic [NUM_REQ-1:0] exp_g;

        // Reset held with every requester asking.
        reset_n     = 1'b0;
        bus.req     = 4'b1111;
        bus.lock    = '0;
        drv_addr[0] = 8'h10;
        drv_addr[1] = 8'h21;
        drv_addr[2] = 8'h32;
        drv_addr[3] = 8'h43;
        apply_addr();
        repeat (3) tick();
        check("rst_gnt", 32'(bus.gnt), 32'h0);
        check("rst_rdata", 32'(bus.rdata), 32'h0);
        check("rst_rom_address", 32'(rom_address), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // Release: round-robin across all four, addresses changing after each grant.
        reset_n = 1'b1;
        step(4'b0001, "rr_gnt0");
        step(4'b0010, "rr_gnt1");
        step(4'b0100, "rr_gnt2");
        step(4'b1000, "rr_gnt3");
        step(4'b0001, "rr_gnt4");
        step(4'b0010, "rr_gnt5");
        step(4'b0100, "rr_gnt6");
        step(4'b1000, "rr_gnt7");
        check("rr_busy", 32'(busy), 32'h1);
        bus.req = '0;
        repeat (ROM_LAT + 1) step(4'b0000, "rr_drain");
        check("rr_idle_busy", 32'(busy), 32'h0);

        // Single requester at address 5A.
        drv_addr[2] = 8'h5A;
        apply_addr();
        bus.req = 4'b0100;
        step(4'b0100, "single_gnt");
        check("single_busy", 32'(busy), 32'h1);
        bus.req = '0;
        step(4'b0000, "single_gnt_drop");
        step(4'b0000, "single_idle");
        check("single_idle_busy", 32'(busy), 32'h0);

        // Pointer wrap: after requester 3, requester 0 precedes 3 again.
        bus.req = 4'b1000;
        step(4'b1000, "wrap_gnt3a");
        bus.req = 4'b1001;
        step(4'b0001, "wrap_gnt0");
        step(4'b1000, "wrap_gnt3b");
        bus.req = '0;
        repeat (ROM_LAT + 1) step(4'b0000, "wrap_drain");

        // Reset with two reads in flight: neither may ever return.
        bus.req = 4'b0011;
        step(4'b0001, "flight_gnt0");
        step(4'b0010, "flight_gnt1");
        reset_n = 1'b0;
        #1;
        check("flight_busy", 32'(busy), 32'h0);
        check("flight_gnt", 32'(bus.gnt), 32'h0);
        check("flight_rvalid", 32'(bus.rvalid), 32'h0);
        sb.delete();
        bus.req = '0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (4) step(4'b0000, "flight_quiet");

        // Two requesters, requester 0 asking for a lock.
        bus.req  = 4'b0011;
        bus.lock = 4'b0001;
        for (int k = 0; k < LOCK_MAX + 2; k++) begin
`ifdef SPRITE_ARB_LOCK_EN
            exp_g = (k < LOCK_MAX) ? 4'b0001 : ((k == LOCK_MAX) ? 4'b0010 : 4'b0001);
`else
            exp_g = (k % 2 == 0) ? 4'b0001 : 4'b0010;
`endif
            step(exp_g, "lock_seq");
        end
        bus.req  = '0;
        bus.lock = '0;
        repeat (ROM_LAT + 1) step(4'b0000, "lock_drain");
        check("final_busy", 32'(busy), 32'h0);
        check("sb_empty", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
